// File: rtl/riscv32_imem_loader_ctrl_pkg.sv
// Shared definitions for the IMEM loader: controller states, byte-lane and hold-counter widths.
package riscv32_imem_loader_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } loader_state_e;

  localparam int LANE_W = 2;
  localparam int HOLD_W = 8;

  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
  localparam logic [LANE_W-1:0] LANE_LAST = '1;
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

endpackage

// File: rtl/riscv32_imem_loader_ctrl_byte_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
// Accepts one byte per cycle whenever byte_en is high; clr wins over byte_en.
module riscv32_byte_packer
  import riscv32_imem_loader_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane_q;
  logic [31:0]       sr_q;
  logic              vld_q;

  // Bytes shift in from the top so byte 0 ends up in bits [7:0] after four shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      sr_q   <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      lane_q <= '0;
      sr_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= byte_en && (lane_q == LANE_LAST);
      if (byte_en) begin
        sr_q   <= {byte_data, sr_q[31:8]};
        lane_q <= lane_q + LANE_ONE;
      end
    end
  end

  assign word_valid = vld_q;
  assign word       = sr_q;

endmodule

// File: rtl/riscv32_imem_loader_ctrl.sv
// Boot loader: holds the core in reset, streams bytes into IMEM words, then releases the core.
// IMEM write lands 1 cycle after a word's 4th byte; byte_ready drops only outside LOAD and on the final write.
module riscv32_imem_loader_ctrl
  import riscv32_imem_loader_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 4096,
  parameter int AW               = 12,
  parameter int RST_HOLD         = 4,
  parameter bit AUTO_START       = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic [AW:0]   load_words,
  input  logic          run_req,
  input  logic          abort,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [AW:0]       DEPTH_W   = (AW+1)'(IMEM_DEPTH_WORDS);
  localparam logic [AW:0]       WORDS_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]     WCNT_ONE  = AW'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

  loader_state_e     state_q, state_d;
  logic [AW:0]       words_q, words_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              error_q, error_d;
  logic              core_rst_n_q;

  logic        in_load, req_ok, word_vld, last_write, byte_en, pk_clr;
  logic [31:0] word;

  assign in_load    = (state_q == ST_LOAD);
  assign req_ok     = (load_words != '0) && (load_words <= DEPTH_W);
  assign imem_we    = word_vld && in_load && !abort;
  assign last_write = imem_we && ({1'b0, wcnt_q} == (words_q - WORDS_ONE));
  assign byte_ready = in_load && !last_write;
  assign byte_en    = byte_valid && byte_ready;
  assign pk_clr     = !in_load || abort;

  riscv32_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word_valid (word_vld),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    error_d = error_q;
    unique case (state_q)
      ST_HALT, ST_RUN: begin
        if (load_req) begin
          if (req_ok) begin
            state_d = ST_LOAD;
            words_d = load_words;
            wcnt_d  = '0;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else if (run_req && (state_q == ST_HALT)) begin
          state_d = ST_RELEASE;
          hold_d  = HOLD_INIT;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_HALT;
          wcnt_d  = '0;
        end else if (last_write) begin
          // wcnt returns to 0 so imem_waddr never shows load_words.
          wcnt_d = '0;
          if (AUTO_START) begin
            state_d = ST_RELEASE;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = ST_HALT;
          end
        end else if (imem_we) begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - HOLD_ONE;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HALT;
      words_q      <= '0;
      wcnt_q       <= '0;
      hold_q       <= '0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      wcnt_q       <= wcnt_d;
      hold_q       <= hold_d;
      error_q      <= error_d;
      core_rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign imem_waddr = wcnt_q;
  assign imem_wdata = word;
  assign core_rst_n = core_rst_n_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
  assign done       = last_write;
  assign error      = error_q;

endmodule

// File: tb/tb_riscv32_imem_loader_ctrl.sv
// Bench for the IMEM loader: byte-stream model predicts every write, done, ready and release timing.
module tb_riscv32_imem_loader_ctrl;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int HOLD  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req, run_req, abort, byte_valid;
  logic [AW:0]   load_words;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, core_rst_n, busy, done, error;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  int tests = 0;
  int fails = 0;
  logic [7:0]  img[$];
  logic [31:0] mem_seen[0:63];

  riscv32_imem_loader_ctrl #(
    .IMEM_DEPTH_WORDS(DEPTH), .AW(AW), .RST_HOLD(HOLD), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_words(load_words),
    .run_req(run_req), .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n, input logic exp_rst, input logic exp_err);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_core_rst_n", 32'(core_rst_n), 32'(exp_rst));
      chk("idle_byte_ready", 32'(byte_ready), 0);
      chk("idle_imem_we",    32'(imem_we),    0);
      chk("idle_done",       32'(done),       0);
      chk("idle_busy",       32'(busy),       0);
      chk("idle_error",      32'(error),      32'(exp_err));
      next_cycle();
    end
    byte_valid = 1'b0;
  endtask

  // The hold window keeps the core in reset for HOLD cycles after the releasing cycle.
  task automatic release_check();
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      chk("rel_core_rst_n", 32'(core_rst_n), 0);
      chk("rel_busy",       32'(busy),       1);
      chk("rel_imem_we",    32'(imem_we),    0);
      next_cycle();
    end
    @(negedge clk);
    chk("run_core_rst_n", 32'(core_rst_n), 1);
    chk("run_busy",       32'(busy),       0);
    next_cycle();
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps. abort_at<0 means no abort.
  task automatic run_load(input int n, input int mode, input int abort_at, input logic with_run);
    int   nacc, total, writes, cyc, pend_idx;
    logic pend, ldone, aborting, acc, exp_we, exp_done, exp_ready;
    logic [31:0] exp_word;
    total = 4 * n;
    load_req   = 1'b1;
    load_words = (AW+1)'(n);
    run_req    = with_run;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("req_busy", 32'(busy), 0);
    next_cycle();
    load_req = 1'b0;
    run_req  = 1'b0;
    nacc = 0; pend = 1'b0; pend_idx = 0; writes = 0; ldone = 1'b0; cyc = 0;
    while (!ldone) begin
      aborting = (abort_at >= 0) && (nacc == abort_at);
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = ((cyc % 2) == 0);
        default: byte_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (aborting || nacc >= total) byte_valid = 1'b0;
      byte_data = byte_valid ? img[nacc] : 8'($urandom);
      abort     = aborting;
      @(negedge clk);
      exp_we    = pend && !aborting;
      exp_done  = exp_we && (pend_idx == n - 1);
      exp_ready = !exp_done;
      chk("load_imem_we",    32'(imem_we),    32'(exp_we));
      chk("load_done",       32'(done),       32'(exp_done));
      chk("load_byte_ready", 32'(byte_ready), 32'(exp_ready));
      chk("load_busy",       32'(busy),       1);
      chk("load_core_rst_n", 32'(core_rst_n), 0);
      chk("load_error",      32'(error),      0);
      if (exp_we) begin
        exp_word = {img[4*pend_idx+3], img[4*pend_idx+2], img[4*pend_idx+1], img[4*pend_idx]};
        chk("load_waddr", 32'(imem_waddr), 32'(pend_idx));
        chk("load_wdata", imem_wdata, exp_word);
        if (pend_idx < 64) mem_seen[pend_idx] = imem_wdata;
        writes++;
      end
      acc  = byte_valid && exp_ready;
      pend = 1'b0;
      if (acc) begin
        nacc++;
        if ((nacc % 4) == 0) begin
          pend     = 1'b1;
          pend_idx = nacc / 4 - 1;
        end
      end
      next_cycle();
      abort      = 1'b0;
      byte_valid = 1'b0;
      cyc++;
      if (aborting || exp_done) ldone = 1'b1;
      if (cyc > 5000) begin
        tests++;
        fails++;
        $error("FAIL load_timeout: observed %0d cycles expected done", cyc);
        ldone = 1'b1;
      end
    end
    if (abort_at >= 0) chk("abort_writes", writes, abort_at / 4);
    else               chk("load_writes",  writes, n);
  endtask

  task automatic fill_random(input int nbytes);
    img.delete();
    for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; run_req = 1'b0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0; load_words = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst_n", 32'(core_rst_n), 0);
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_imem_we",    32'(imem_we),    0);
    chk("rst_waddr",      32'(imem_waddr), 0);
    chk("rst_wdata",      imem_wdata,      0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_done",       32'(done),       0);
    chk("rst_error",      32'(error),      0);
    next_cycle();
    rst_n = 1'b1;

    idle_check(10, 1'b0, 1'b0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run_load(2, 0, -1, 1'b0);
    chk("img_addr0", mem_seen[0], 32'h0000_0013);
    chk("img_addr1", mem_seen[1], 32'h00A0_0093);
    release_check();
    idle_check(3, 1'b1, 1'b0);

    // From RUN, load_req beats run_req.
    fill_random(12);
    run_load(3, 2, -1, 1'b1);
    release_check();

    fill_random(12);
    run_load(3, 1, 6, 1'b0);
    idle_check(4, 1'b0, 1'b0);

    load_req = 1'b1; load_words = '0;
    @(negedge clk);
    chk("err0_imem_we", 32'(imem_we), 0);
    next_cycle();
    load_req = 1'b0;
    idle_check(3, 1'b0, 1'b1);
    load_req = 1'b1; load_words = (AW+1)'(DEPTH + 1);
    @(negedge clk);
    chk("errbig_imem_we", 32'(imem_we), 0);
    next_cycle();
    load_req = 1'b0;
    idle_check(3, 1'b0, 1'b1);

    fill_random(84);
    run_load(21, 2, -1, 1'b0);
    release_check();
    idle_check(2, 1'b1, 1'b0);

    // Full-depth length is legal; abort early to keep the run short.
    fill_random(16);
    run_load(DEPTH, 0, 9, 1'b0);
    idle_check(2, 1'b0, 1'b0);

    run_req = 1'b1;
    @(negedge clk);
    chk("runreq_busy", 32'(busy), 0);
    next_cycle();
    run_req = 1'b0;
    release_check();

    fill_random(8);
    run_load(2, 2, -1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_core_rst_n", 32'(core_rst_n), 0);
    chk("async_busy",       32'(busy),       0);
    chk("async_byte_ready", 32'(byte_ready), 0);
    next_cycle();
    rst_n = 1'b1;
    idle_check(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
